ddr_rd_scheduler: RTL and testbench
===================================

DDR_RD_SCHEDULER -- requirements
Module: ddr_rd_scheduler

Interface
REQ-001 SHALL have parameter MAX_BURST_BEATS, default 64, meaning max beats per AR burst (1..64, power of 2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, meaning max AR bursts awaiting final rlast.
REQ-003 SHALL have port ddr_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port base_addr  in  64  byte address; bits [5:0] must be zero.
REQ-007 SHALL have port transfer_length  in  64  transfer size in bytes.
REQ-008 SHALL have ports busy  out  1, done  out  1 and err  out  1: active, one-cycle completion pulse, sticky response error.
REQ-009 SHALL have ports to_ddr_arvalid  out  1, to_ddr_arready  in  1, to_ddr_araddr  out  64 and to_ddr_arlen  out  8.
REQ-010 SHALL have ports to_ddr_arburst  out  2, to_ddr_arsize  out  3, to_ddr_arcache  out  4, to_ddr_arprot  out  3 and to_ddr_aruser  out  4.
REQ-011 SHALL have ports to_ddr_rvalid  in  1, to_ddr_rready  in  1, to_ddr_rlast  in  1 and to_ddr_rresp  in  2; the R channel is observe-only.
REQ-012 SHALL have port outstanding  out  4  current count of in-flight bursts.

Function
REQ-013 SHALL drive constants: arburst=2'b01 (INCR), arsize=3'b110 (64 B/beat), arcache=4'b0011, arprot=3'b000, aruser=4'b0000.
REQ-014 SHALL compute total beats as ceil(transfer_length/64), captured on start in IDLE.
REQ-015 SHALL have FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-016 SHALL, in IDLE, move to ISSUE on start when beats>0, or to DONE when beats==0 (no AR issued).
REQ-017 SHALL ignore start when not in IDLE.
REQ-018 SHALL set each burst's beats to min(remaining beats, MAX_BURST_BEATS, beats to next 4 KB boundary), with arlen=beats-1.
REQ-019 SHALL hold araddr and arlen stable while arvalid=1 and arready=0; arvalid SHALL NOT drop before handshake.
REQ-020 SHALL, on an AR handshake, advance address by beats*64, subtract beats from remaining and increment outstanding.
REQ-021 SHALL decrement outstanding on each cycle with rvalid&rready&rlast; simultaneous AR handshake and rlast SHALL leave it unchanged.
REQ-022 SHALL, when outstanding==MAX_OUTSTANDING, keep arvalid low (a new request may not be raised); arvalid already high SHALL stay high.
REQ-023 SHALL move ISSUE->DRAIN when the final AR handshake occurs; next-request arvalid SHALL be 0 from the following cycle.
REQ-024 SHALL move DRAIN->DONE when outstanding reaches 0.
REQ-025 SHALL assert done for exactly the DONE cycle, then return to IDLE; busy=1 in ISSUE and DRAIN.
REQ-026 SHALL set err on any rvalid&rready beat with rresp!=2'b00; err SHALL clear on the next accepted start.
REQ-027 SHALL issue the first AR with arvalid high one cycle after start (latency 1).
REQ-028 SHALL use 64-bit address arithmetic that wraps modulo 2^64 without flagging.

Reset
REQ-029 SHALL, on rst, enter IDLE with arvalid=0, busy=0, done=0, err=0, outstanding=0, araddr=0, arlen=0 and remaining=0 on the next edge.
REQ-030 SHALL treat rst mid-transfer as an abort: it discards in-flight accounting and drops arvalid even before handshake, with no done pulse.

Structure
REQ-031 SHALL place FSM state enum, AXI constants (INCR, SIZE_64B, cache/prot/user values) and BEAT_BYTES=64 in shared package traffic_gen_pkg.
REQ-032 SHALL be a single module with no sub-modules; burst-length computation is inline combinational logic.

Verification
REQ-033 SHALL test: base=0x0, len=8192, arready=1, R returns immediately -> 2 ARs (0x0 arlen=63, 0x1000 arlen=63), then done pulse, err=0.
REQ-034 SHALL test: base=0xFC0, len=256 -> ARs (0xFC0 arlen=0), (0x1000 arlen=2); no 4 KB crossing.
REQ-035 SHALL test: len=100 -> single AR arlen=1 (2 beats); len=0 -> done one cycle after idle-state start, no arvalid.
REQ-036 SHALL test: len=64 KB, rlast withheld -> exactly 8 ARs then arvalid stays 0; release one rlast -> ninth AR issues, outstanding back to 8.
REQ-037 SHALL test: arready held 0 for 5 cycles with arvalid high -> araddr/arlen constant; a simultaneous AR handshake and rlast -> outstanding unchanged.
REQ-038 SHALL test: rresp=2'b10 on one beat -> err=1 through done; rst asserted mid-ISSUE -> next cycle arvalid=0, outstanding=0, no done.

Source files
------------

// File: rtl/traffic_gen_pkg.sv
// rtl/traffic_gen_pkg.sv - shared FSM states and AXI read-channel constants
package traffic_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [3:0] AXI_CACHE_VAL  = 4'b0011;
  localparam logic [2:0] AXI_PROT_VAL   = 3'b000;
  localparam logic [3:0] AXI_USER_VAL   = 4'b0000;
  localparam int         BEAT_BYTES     = 64;

endpackage

// File: rtl/ddr_rd_scheduler.sv
// rtl/ddr_rd_scheduler.sv - splits a byte transfer into 4 KB-safe AXI read bursts
module ddr_rd_scheduler
  import traffic_gen_pkg::*;
#(
  parameter int MAX_BURST_BEATS = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        ddr_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic [63:0] transfer_length,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        to_ddr_arvalid,
  input  logic        to_ddr_arready,
  output logic [63:0] to_ddr_araddr,
  output logic [7:0]  to_ddr_arlen,
  output logic [1:0]  to_ddr_arburst,
  output logic [2:0]  to_ddr_arsize,
  output logic [3:0]  to_ddr_arcache,
  output logic [2:0]  to_ddr_arprot,
  output logic [3:0]  to_ddr_aruser,
  input  logic        to_ddr_rvalid,
  input  logic        to_ddr_rready,
  input  logic        to_ddr_rlast,
  input  logic [1:0]  to_ddr_rresp,
  output logic [3:0]  outstanding
);

  localparam logic [6:0] MAX_B   = 7'(MAX_BURST_BEATS);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t      state_q;
  logic        arvalid_q, busy_q, done_q, err_q;
  logic [63:0] addr_q;
  logic [6:0]  arlen_q;
  logic [58:0] rem_q;
  logic [3:0]  out_q;

  logic [58:0] beats_in, rem_d, src_rem;
  logic [63:0] addr_d;
  logic [6:0]  cur_beats, nb;
  logic [5:0]  src_blk;
  logic [3:0]  out_d;
  logic        ar_hs, r_last, r_err;

  // addr_q/rem_q describe the burst currently presented; the next one is sized from their post-handshake values
  always_comb begin
    beats_in  = {1'b0, transfer_length[63:6]} + {58'd0, |transfer_length[5:0]};
    ar_hs     = arvalid_q & to_ddr_arready;
    r_last    = to_ddr_rvalid & to_ddr_rready & to_ddr_rlast;
    r_err     = to_ddr_rvalid & to_ddr_rready & (to_ddr_rresp != 2'b00);
    cur_beats = arlen_q + 7'd1;
    addr_d    = ar_hs ? addr_q + {51'd0, cur_beats, 6'd0} : addr_q;
    rem_d     = ar_hs ? rem_q - {52'd0, cur_beats} : rem_q;
    src_blk   = (state_q == ST_IDLE) ? base_addr[11:6] : addr_d[11:6];
    src_rem   = (state_q == ST_IDLE) ? beats_in : rem_d;
    nb        = 7'd64 - {1'b0, src_blk};
    if (nb > MAX_B) nb = MAX_B;
    if (src_rem < {52'd0, nb}) nb = src_rem[6:0];
    out_d = out_q;
    if (ar_hs && !r_last) out_d = out_q + 4'd1;
    else if (!ar_hs && r_last && out_q != 4'd0) out_d = out_q - 4'd1;
  end

  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= 4'd0;
      addr_q    <= 64'd0;
      arlen_q   <= 7'd0;
      rem_q     <= 59'd0;
    end else begin
      out_q <= out_d;
      if (r_err) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q <= r_err;
            if (beats_in == 59'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_ISSUE;
              busy_q    <= 1'b1;
              arvalid_q <= 1'b1;
              addr_q    <= base_addr;
              rem_q     <= beats_in;
              arlen_q   <= nb - 7'd1;
            end
          end
        end
        ST_ISSUE: begin
          addr_q <= addr_d;
          rem_q  <= rem_d;
          if (ar_hs && rem_d == 59'd0) begin
            state_q   <= ST_DRAIN;
            arvalid_q <= 1'b0;
          end else if (!arvalid_q || ar_hs) begin
            // a pending request is never withdrawn; only a fresh one is gated by the window
            arvalid_q <= (out_d < MAX_OUT);
            arlen_q   <= nb - 7'd1;
          end
        end
        ST_DRAIN: begin
          if (out_d == 4'd0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign outstanding    = out_q;
  assign to_ddr_arvalid = arvalid_q;
  assign to_ddr_araddr  = addr_q;
  assign to_ddr_arlen   = {1'b0, arlen_q};
  assign to_ddr_arburst = AXI_BURST_INCR;
  assign to_ddr_arsize  = AXI_SIZE_64B;
  assign to_ddr_arcache = AXI_CACHE_VAL;
  assign to_ddr_arprot  = AXI_PROT_VAL;
  assign to_ddr_aruser  = AXI_USER_VAL;

endmodule

// File: tb/tb_ddr_rd_scheduler.sv
// tb/tb_ddr_rd_scheduler.sv - self-checking bench for ddr_rd_scheduler
module tb_ddr_rd_scheduler;

  logic        ddr_clk, rst, start;
  logic [63:0] base_addr, transfer_length;
  logic        busy, done, err;
  logic        to_ddr_arvalid, to_ddr_arready;
  logic [63:0] to_ddr_araddr;
  logic [7:0]  to_ddr_arlen;
  logic [1:0]  to_ddr_arburst;
  logic [2:0]  to_ddr_arsize;
  logic [3:0]  to_ddr_arcache;
  logic [2:0]  to_ddr_arprot;
  logic [3:0]  to_ddr_aruser;
  logic        to_ddr_rvalid, to_ddr_rready, to_ddr_rlast;
  logic [1:0]  to_ddr_rresp;
  logic [3:0]  outstanding;

  ddr_rd_scheduler #(.MAX_BURST_BEATS(64), .MAX_OUTSTANDING(8)) dut (
    .ddr_clk(ddr_clk), .rst(rst), .start(start),
    .base_addr(base_addr), .transfer_length(transfer_length),
    .busy(busy), .done(done), .err(err),
    .to_ddr_arvalid(to_ddr_arvalid), .to_ddr_arready(to_ddr_arready),
    .to_ddr_araddr(to_ddr_araddr), .to_ddr_arlen(to_ddr_arlen),
    .to_ddr_arburst(to_ddr_arburst), .to_ddr_arsize(to_ddr_arsize),
    .to_ddr_arcache(to_ddr_arcache), .to_ddr_arprot(to_ddr_arprot),
    .to_ddr_aruser(to_ddr_aruser),
    .to_ddr_rvalid(to_ddr_rvalid), .to_ddr_rready(to_ddr_rready),
    .to_ddr_rlast(to_ddr_rlast), .to_ddr_rresp(to_ddr_rresp),
    .outstanding(outstanding)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  typedef struct {
    logic [63:0] base;
    logic [63:0] len;
    int          rdy;
    int          n_ar;
    logic [63:0] a0;
    int          l0;
    logic [63:0] a1;
    int          l1;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] ar_addr_q[$];
  int          ar_len_q[$];
  int          rsp_q[$];
  logic [63:0] exp_a[$];
  int          exp_l[$];
  int          out_model, cur_beat, beat_cnt, err_at;
  bit          rsp_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    start = 1'b0; to_ddr_arready = 1'b0;
    to_ddr_rvalid = 1'b0; to_ddr_rready = 1'b0; to_ddr_rlast = 1'b0; to_ddr_rresp = 2'b00;
  endtask

  task automatic clear_track();
    ar_addr_q.delete(); ar_len_q.delete(); rsp_q.delete();
    out_model = 0; cur_beat = 0; beat_cnt = 0; err_at = -1; rsp_en = 1'b0;
  endtask

  // Memory side: returns the beats of each accepted burst in order, with random gaps.
  task automatic drive_r();
    if (rsp_en && rsp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      to_ddr_rvalid = 1'b1; to_ddr_rready = 1'b1;
      to_ddr_rlast  = (cur_beat == rsp_q[0] - 1);
      to_ddr_rresp  = (beat_cnt == err_at) ? 2'b10 : 2'b00;
    end else begin
      to_ddr_rvalid = 1'b0; to_ddr_rready = 1'($urandom_range(0, 1));
      to_ddr_rlast  = 1'($urandom_range(0, 1)); to_ddr_rresp = 2'b11;
    end
  endtask

  task automatic tick();
    bit hs, rl;
    hs = to_ddr_arvalid && to_ddr_arready;
    rl = to_ddr_rvalid && to_ddr_rready && to_ddr_rlast;
    if (hs) begin
      ar_addr_q.push_back(to_ddr_araddr);
      ar_len_q.push_back(int'(to_ddr_arlen));
      rsp_q.push_back(int'(to_ddr_arlen) + 1);
    end
    if (to_ddr_rvalid && to_ddr_rready) begin
      beat_cnt++;
      if (to_ddr_rlast) begin
        cur_beat = 0;
        if (rsp_en && rsp_q.size() > 0) void'(rsp_q.pop_front());
      end else begin
        cur_beat++;
      end
    end
    if (hs && !rl) out_model++;
    else if (!hs && rl && out_model > 0) out_model--;
    @(posedge ddr_clk);
    #1;
  endtask

  // Reference: split the byte range into beats, then cut at 64 beats and at every 4 KB line.
  task automatic build_model(input logic [63:0] base, input logic [63:0] len);
    longint unsigned beats, to4k, b;
    logic [63:0] a;
    exp_a.delete(); exp_l.delete();
    beats = len / 64 + (((len % 64) != 0) ? 1 : 0);
    a = base;
    while (beats > 0) begin
      to4k = (4096 - (a % 4096)) / 64;
      b = beats;
      if (b > 64) b = 64;
      if (b > to4k) b = to4k;
      exp_a.push_back(a);
      exp_l.push_back(int'(b) - 1);
      a = a + b * 64;
      beats = beats - b;
    end
  endtask

  task automatic run_xfer(input logic [63:0] base, input logic [63:0] len, input int rdy_pct, input int e_at);
    longint unsigned nbeats;
    int  k, idx;
    bit  exp_err, pend, was_low;
    clear_track();
    build_model(base, len);
    err_at = e_at;
    rsp_en = 1'b1;
    nbeats = len / 64 + (((len % 64) != 0) ? 1 : 0);
    exp_err = (e_at >= 0) && (64'(e_at) < nbeats);
    base_addr = base; transfer_length = len; start = 1'b1; to_ddr_arready = 1'b0;
    tick();
    start = 1'b0;
    chk("start_arvalid", 64'(to_ddr_arvalid), 64'(nbeats != 0));
    chk("start_done", 64'(done), 64'(nbeats == 0));
    k = 0;
    while (!done && k < 20000) begin
      to_ddr_arready = ($urandom_range(0, 99) < rdy_pct);
      drive_r();
      pend    = to_ddr_arvalid && !to_ddr_arready;
      was_low = !to_ddr_arvalid;
      tick();
      k++;
      chk("outstanding", 64'(outstanding), 64'(out_model));
      if (pend) chk("arvalid_held", 64'(to_ddr_arvalid), 64'd1);
      if (was_low && to_ddr_arvalid) chk("arvalid_window", 64'(outstanding < 4'd8), 64'd1);
      idx = ar_addr_q.size();
      if (to_ddr_arvalid) begin
        if (idx < exp_a.size()) begin
          chk("cur_araddr", to_ddr_araddr, exp_a[idx]);
          chk("cur_arlen", 64'(to_ddr_arlen), 64'(exp_l[idx]));
        end else begin
          chk("extra_arvalid", 64'(to_ddr_arvalid), 64'd0);
        end
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: no done after %0d cycles for len %0d", k, len);
    end else begin
      chk("done_err", 64'(err), 64'(exp_err));
      chk("done_busy", 64'(busy), 64'd0);
      chk("done_outstanding", 64'(outstanding), 64'd0);
    end
    quiet();
    rsp_en = 1'b0;
    tick();
    chk("done_single_cycle", 64'(done), 64'd0);
    chk("idle_err", 64'(err), 64'(exp_err));
    chk("ar_count", 64'(ar_addr_q.size()), 64'(exp_a.size()));
    for (int i = 0; i < ar_addr_q.size() && i < exp_a.size(); i++) begin
      chk("ar_addr", ar_addr_q[i], exp_a[i]);
      chk("ar_len", 64'(ar_len_q[i]), 64'(exp_l[i]));
    end
  endtask

  initial begin
    vecs[0] = '{64'h0,                   64'd8192, 100, 2, 64'h0,      63, 64'h1000, 63};
    vecs[1] = '{64'hFC0,                 64'd256,  100, 2, 64'hFC0,    0,  64'h1000, 2};
    vecs[2] = '{64'h0,                   64'd100,  100, 1, 64'h0,      1,  64'h0,    0};
    vecs[3] = '{64'h40,                  64'd64,   70,  1, 64'h40,     0,  64'h0,    0};
    vecs[4] = '{64'h800,                 64'd4096, 50,  2, 64'h800,    31, 64'h1000, 31};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'd128,  100, 2, 64'hFFFF_FFFF_FFFF_FFC0, 0, 64'h0, 0};
    vecs[6] = '{64'h2000,                64'd65,   30,  1, 64'h2000,   1,  64'h0,    0};
    vecs[7] = '{64'h3F80,                64'd8192, 80,  3, 64'h3F80,   1,  64'h4000, 63};

    quiet();
    clear_track();
    base_addr = 64'd0; transfer_length = 64'd0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_arvalid", 64'(to_ddr_arvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_araddr", to_ddr_araddr, 64'd0);
    chk("rst_arlen", 64'(to_ddr_arlen), 64'd0);
    chk("const_arburst", 64'(to_ddr_arburst), 64'h1);
    chk("const_arsize", 64'(to_ddr_arsize), 64'h6);
    chk("const_arcache", 64'(to_ddr_arcache), 64'h3);
    chk("const_arprot", 64'(to_ddr_arprot), 64'h0);
    chk("const_aruser", 64'(to_ddr_aruser), 64'h0);
    rst = 1'b0;
    tick();

    foreach (vecs[v]) begin
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].rdy, -1);
      chk("vec_n_ar", 64'(ar_addr_q.size()), 64'(vecs[v].n_ar));
      if (ar_addr_q.size() > 0) begin
        chk("vec_a0", ar_addr_q[0], vecs[v].a0);
        chk("vec_l0", 64'(ar_len_q[0]), 64'(vecs[v].l0));
      end
      if (vecs[v].n_ar > 1 && ar_addr_q.size() > 1) begin
        chk("vec_a1", ar_addr_q[1], vecs[v].a1);
        chk("vec_l1", 64'(ar_len_q[1]), 64'(vecs[v].l1));
      end
    end

    // Outstanding window: no R traffic, so the ninth burst waits for one rlast.
    clear_track();
    base_addr = 64'h0; transfer_length = 64'd65536; start = 1'b1; to_ddr_arready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("lim_ar_count", 64'(ar_addr_q.size()), 64'd8);
    chk("lim_arvalid", 64'(to_ddr_arvalid), 64'd0);
    chk("lim_outstanding", 64'(outstanding), 64'd8);
    to_ddr_rvalid = 1'b1; to_ddr_rready = 1'b1; to_ddr_rlast = 1'b1;
    tick();
    to_ddr_rvalid = 1'b0; to_ddr_rready = 1'b0; to_ddr_rlast = 1'b0;
    chk("lim_release_outstanding", 64'(outstanding), 64'd7);
    chk("lim_release_arvalid", 64'(to_ddr_arvalid), 64'd1);
    tick();
    chk("lim_ar9_count", 64'(ar_addr_q.size()), 64'd9);
    if (ar_addr_q.size() > 8) chk("lim_ar9_addr", ar_addr_q[8], 64'h8000);
    chk("lim_ar9_outstanding", 64'(outstanding), 64'd8);
    chk("lim_ar9_arvalid", 64'(to_ddr_arvalid), 64'd0);
    to_ddr_arready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;

    // Stalled AR holds its payload; a late start is ignored; AR handshake plus rlast nets zero.
    clear_track();
    base_addr = 64'h0; transfer_length = 64'd8192; start = 1'b1; to_ddr_arready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; base_addr = 64'h5000; transfer_length = 64'd64;
      end
      tick();
      start = 1'b0;
      chk("stall_arvalid", 64'(to_ddr_arvalid), 64'd1);
      chk("stall_araddr", to_ddr_araddr, 64'h0);
      chk("stall_arlen", 64'(to_ddr_arlen), 64'd63);
    end
    to_ddr_arready = 1'b1;
    tick();
    chk("second_araddr", to_ddr_araddr, 64'h1000);
    chk("second_outstanding", 64'(outstanding), 64'd1);
    to_ddr_rvalid = 1'b1; to_ddr_rready = 1'b1; to_ddr_rlast = 1'b1;
    tick();
    chk("simul_outstanding", 64'(outstanding), 64'd1);
    chk("simul_arvalid", 64'(to_ddr_arvalid), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    quiet();
    tick();
    chk("drain_no_done", 64'(done), 64'd0);
    to_ddr_rvalid = 1'b1; to_ddr_rready = 1'b1; to_ddr_rlast = 1'b1;
    tick();
    quiet();
    chk("drain_done", 64'(done), 64'd1);
    chk("drain_done_busy", 64'(busy), 64'd0);
    tick();
    chk("drain_done_pulse", 64'(done), 64'd0);

    // Error response is sticky through done, then cleared by the next start.
    run_xfer(64'h0, 64'd1024, 100, 5);
    chk("err_sticky", 64'(err), 64'd1);
    run_xfer(64'h1000, 64'd0, 100, -1);

    // Abort mid-ISSUE with bursts in flight and a request pending.
    clear_track();
    base_addr = 64'h0; transfer_length = 64'd65536; start = 1'b1; to_ddr_arready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    to_ddr_arready = 1'b0;
    tick();
    chk("abort_pre_outstanding", 64'(outstanding), 64'd3);
    chk("abort_pre_arvalid", 64'(to_ddr_arvalid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_arvalid", 64'(to_ddr_arvalid), 64'd0);
    chk("abort_outstanding", 64'(outstanding), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle_arvalid", 64'(to_ddr_arvalid), 64'd0);
    end

    for (int t = 0; t < 25; t++) begin
      logic [63:0] b, l;
      int rdy, e;
      b = {$urandom(), $urandom()};
      b[5:0] = 6'd0;
      if (t % 5 == 0) b[63:12] = '1;
      if (t % 3 == 0) b[11:6] = 6'h3F - 6'($urandom_range(0, 3));
      l   = 64'($urandom_range(0, 12000));
      rdy = int'($urandom_range(20, 100));
      e   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 200)) : -1;
      run_xfer(b, l, rdy, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
